// File: rtl/ti_cic_sequencer.sv
// Timing/control sequencer for the 4-lane time-interleaved mixer + CIC decimator.
// Generates lane strobes, filter reset/enable, and a valid pulse per decimated output pair.
module ti_cic_sequencer #(
    parameter int FLUSH_CYC  = 8,
    parameter int DEC        = 8,
    parameter int SETTLE_OUT = 4,
    parameter int CNT_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    output logic [3:0]       o_ph,
    output logic             o_ph1_2,
    output logic             o_cic_res,
    output logic             o_cic_en,
    output logic             o_out_valid,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_out_cnt
);

    localparam int RND_N = DEC / 4;
    localparam int RND_W = (RND_N > 1) ? $clog2(RND_N) : 1;
    localparam int FL_W  = $clog2(FLUSH_CYC) + 1;
    localparam int EV_W  = $clog2(SETTLE_OUT) + 1;

    localparam logic [RND_W-1:0] RND_LAST = RND_W'(RND_N - 1);
    localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLUSH_CYC - 1);
    localparam logic [EV_W-1:0]  EV_LAST  = EV_W'(SETTLE_OUT - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FLUSH  = 2'd1;
    localparam logic [1:0] S_WARMUP = 2'd2;
    localparam logic [1:0] S_RUN    = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       r_phase;
    logic [RND_W-1:0] r_round;
    logic [FL_W-1:0]  r_flush_cnt;
    logic [EV_W-1:0]  r_evt_cnt;
    logic [3:0]       r_ph;
    logic             r_ph1_2;
    logic             r_cic_res;
    logic             r_cic_en;
    logic             r_out_valid;
    logic             r_busy;
    logic [CNT_W-1:0] r_out_cnt;

    logic [1:0]       w_state_next;
    logic [1:0]       w_phase_next;
    logic [RND_W-1:0] w_round_next;
    logic [FL_W-1:0]  w_flush_next;
    logic [EV_W-1:0]  w_evt_next;
    logic             w_out_evt;
    logic             w_cnt_clr;
    logic             w_valid_next;
    logic             w_busy_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [3:0]       w_ph_next;

    always_comb begin
        w_out_evt    = (r_phase == 2'd3) && (r_round == RND_LAST);
        w_state_next = r_state;
        w_phase_next = r_phase;
        w_round_next = r_round;
        w_flush_next = r_flush_cnt;
        w_evt_next   = r_evt_cnt;
        w_cnt_clr    = 1'b0;

        if (r_state == S_IDLE) begin
            if (i_start && !i_stop) begin
                w_state_next = S_FLUSH;
                w_phase_next = 2'd0;
                w_round_next = '0;
                w_flush_next = '0;
                w_cnt_clr    = 1'b1;
            end
        end else if (i_stop) begin
            w_state_next = S_IDLE;
            w_phase_next = 2'd0;
            w_round_next = '0;
            w_flush_next = '0;
            w_evt_next   = '0;
        end else begin
            w_phase_next = r_phase + 2'd1;
            if (r_phase == 2'd3) begin
                w_round_next = (r_round == RND_LAST) ? '0 : r_round + RND_W'(1);
            end
            case (r_state)
                S_FLUSH: begin
                    w_flush_next = r_flush_cnt + FL_W'(1);
                    // Phase wraps to 0 on this edge because FLUSH_CYC is a multiple of 4.
                    if (r_flush_cnt == FL_LAST) begin
                        w_state_next = S_WARMUP;
                        w_round_next = '0;
                        w_evt_next   = '0;
                    end
                end
                S_WARMUP: begin
                    if (w_out_evt) begin
                        w_evt_next = r_evt_cnt + EV_W'(1);
                        if (r_evt_cnt == EV_LAST) begin
                            w_state_next = S_RUN;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    assign w_busy_next  = (w_state_next != S_IDLE);
    assign w_valid_next = (w_state_next == S_RUN) && (w_phase_next == 2'd3) &&
                          (w_round_next == RND_LAST);
    assign w_cnt_next   = w_cnt_clr ? '0 : r_out_cnt + CNT_W'(w_valid_next);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ph
            assign w_ph_next[gi] = w_busy_next && (w_phase_next == 2'(gi));
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_phase     <= 2'd0;
            r_round     <= '0;
            r_flush_cnt <= '0;
            r_evt_cnt   <= '0;
            r_ph        <= 4'd0;
            r_ph1_2     <= 1'b0;
            r_cic_res   <= 1'b1;
            r_cic_en    <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_out_cnt   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_phase     <= w_phase_next;
            r_round     <= w_round_next;
            r_flush_cnt <= w_flush_next;
            r_evt_cnt   <= w_evt_next;
            r_ph        <= w_ph_next;
            r_ph1_2     <= w_ph_next[0] && !w_round_next[0];
            r_cic_res   <= (w_state_next == S_IDLE) || (w_state_next == S_FLUSH);
            r_cic_en    <= (w_state_next == S_WARMUP) || (w_state_next == S_RUN);
            r_out_valid <= w_valid_next;
            r_busy      <= w_busy_next;
            r_out_cnt   <= w_cnt_next;
        end
    end

    assign o_ph        = r_ph;
    assign o_ph1_2     = r_ph1_2;
    assign o_cic_res   = r_cic_res;
    assign o_cic_en    = r_cic_en;
    assign o_out_valid = r_out_valid;
    assign o_busy      = r_busy;
    assign o_out_cnt   = r_out_cnt;

endmodule

// File: tb/tb_ti_cic_sequencer.sv
// Self-checking bench for ti_cic_sequencer: checkpoint tables, hand sequences and
// randomized START/STOP traffic against a time-since-start arithmetic model.
module tb_ti_cic_sequencer;

    localparam int FLUSH_CYC  = 8;
    localparam int DEC        = 8;
    localparam int SETTLE_OUT = 2;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [3:0]  ph,   ph_w;
    logic        ph12, ph12_w;
    logic        res,  res_w;
    logic        en,   en_w;
    logic        valid, valid_w;
    logic        busy, busy_w;
    logic [15:0] cnt;
    logic [1:0]  cnt_w;

    int n_vec = 0;
    int n_err = 0;

    bit m_active = 0;
    int m_t      = 0;
    int m_cnt    = 0;

    typedef struct {
        int          cyc;
        logic        start;
        logic        stop;
        logic [3:0]  ph;
        logic        ph12;
        logic        res;
        logic        en;
        logic        valid;
        logic        busy;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    ti_cic_sequencer #(
        .FLUSH_CYC(FLUSH_CYC), .DEC(DEC), .SETTLE_OUT(SETTLE_OUT), .CNT_W(16)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
        .o_ph(ph), .o_ph1_2(ph12), .o_cic_res(res), .o_cic_en(en),
        .o_out_valid(valid), .o_busy(busy), .o_out_cnt(cnt)
    );

    ti_cic_sequencer #(
        .FLUSH_CYC(FLUSH_CYC), .DEC(DEC), .SETTLE_OUT(SETTLE_OUT), .CNT_W(2)
    ) dut_w (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
        .o_ph(ph_w), .o_ph1_2(ph12_w), .o_cic_res(res_w), .o_cic_en(en_w),
        .o_out_valid(valid_w), .o_busy(busy_w), .o_out_cnt(cnt_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int c, input logic s, input logic p, input logic [3:0] eph,
                                input logic e12, input logic eres, input logic een,
                                input logic eval, input logic ebusy, input logic [15:0] ecnt);
        vec_t v;
        v.cyc = c; v.start = s; v.stop = p; v.ph = eph; v.ph12 = e12; v.res = eres;
        v.en = een; v.valid = eval; v.busy = ebusy; v.cnt = ecnt;
        return v;
    endfunction

    function automatic logic [24:0] dut_pack();
        return {ph, ph12, res, en, valid, busy, cnt};
    endfunction

    // Model: everything follows from the number of cycles since the START that began the run.
    function automatic bit model_valid();
        int u;
        if (!m_active || m_t < FLUSH_CYC) return 1'b0;
        u = m_t - FLUSH_CYC;
        return (u >= SETTLE_OUT * DEC) && (u % DEC == DEC - 1);
    endfunction

    function automatic logic [24:0] model_pack();
        int u, phase, round;
        logic [3:0] eph;
        logic e12, eres, een, ebusy;
        logic [15:0] ecnt;
        u     = (m_t < FLUSH_CYC) ? m_t : m_t - FLUSH_CYC;
        phase = u % 4;
        round = (u / 4) % (DEC / 4);
        eph   = m_active ? (4'b0001 << phase) : 4'b0000;
        e12   = m_active && (phase == 0) && (round % 2 == 0);
        eres  = !m_active || (m_t < FLUSH_CYC);
        een   = m_active && (m_t >= FLUSH_CYC);
        ebusy = m_active;
        ecnt  = m_cnt[15:0];
        return {eph, e12, eres, een, model_valid(), ebusy, ecnt};
    endfunction

    function automatic void model_edge(input logic s, input logic p);
        if (!m_active) begin
            if (s && !p) begin
                m_active = 1'b1;
                m_t      = 0;
                m_cnt    = 0;
            end
        end else if (p) begin
            m_active = 1'b0;
        end else begin
            m_t++;
        end
        if (model_valid()) m_cnt++;
    endfunction

    task automatic check(input string name, input int cyc, input logic [24:0] act,
                         input logic [24:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic p);
        logic [1:0] mc;
        start = s;
        stop  = p;
        @(posedge clk);
        model_edge(s, p);
        #1;
        mc = m_cnt[1:0];
        check("model", m_t, dut_pack(), model_pack());
        check("model_cntw2", m_t, 25'(cnt_w), 25'(mc));
    endtask

    task automatic run_table(input int lo, input int hi);
        int cur = 0;
        vec_t v;
        for (int i = lo; i <= hi; i++) begin
            v = tbl[i];
            while (cur < v.cyc) begin
                step(1'b0, 1'b0);
                cur++;
            end
            step(v.start, v.stop);
            cur++;
            check("tbl", v.cyc, dut_pack(),
                  {v.ph, v.ph12, v.res, v.en, v.valid, v.busy, v.cnt});
        end
    endtask

    localparam logic [24:0] RST_PACK = {4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};

    initial begin
        logic [1:0] wrap_seen[5];
        logic [1:0] wrap_exp[5];
        int n_seen;

        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        // Nominal run, STOP from RUN, START+STOP together in IDLE.
        tbl.push_back(mk( 0, 1, 0, 4'b0001, 1, 1, 0, 0, 1, 16'd0));
        tbl.push_back(mk( 1, 0, 0, 4'b0010, 0, 1, 0, 0, 1, 16'd0));
        tbl.push_back(mk( 3, 0, 0, 4'b1000, 0, 1, 0, 0, 1, 16'd0));
        tbl.push_back(mk( 4, 0, 0, 4'b0001, 0, 1, 0, 0, 1, 16'd0));
        tbl.push_back(mk( 7, 0, 0, 4'b1000, 0, 1, 0, 0, 1, 16'd0));
        tbl.push_back(mk( 8, 0, 0, 4'b0001, 1, 0, 1, 0, 1, 16'd0));
        tbl.push_back(mk(15, 0, 0, 4'b1000, 0, 0, 1, 0, 1, 16'd0));
        tbl.push_back(mk(23, 0, 0, 4'b1000, 0, 0, 1, 0, 1, 16'd0));
        tbl.push_back(mk(24, 0, 0, 4'b0001, 1, 0, 1, 0, 1, 16'd0));
        tbl.push_back(mk(28, 0, 0, 4'b0001, 0, 0, 1, 0, 1, 16'd0));
        tbl.push_back(mk(31, 0, 0, 4'b1000, 0, 0, 1, 1, 1, 16'd1));
        tbl.push_back(mk(32, 0, 0, 4'b0001, 1, 0, 1, 0, 1, 16'd1));
        tbl.push_back(mk(36, 0, 0, 4'b0001, 0, 0, 1, 0, 1, 16'd1));
        tbl.push_back(mk(39, 0, 0, 4'b1000, 0, 0, 1, 1, 1, 16'd2));
        tbl.push_back(mk(40, 0, 0, 4'b0001, 1, 0, 1, 0, 1, 16'd2));
        tbl.push_back(mk(47, 0, 0, 4'b1000, 0, 0, 1, 1, 1, 16'd3));
        tbl.push_back(mk(48, 0, 1, 4'b0000, 0, 1, 0, 0, 0, 16'd3));
        tbl.push_back(mk(49, 1, 1, 4'b0000, 0, 1, 0, 0, 0, 16'd3));
        tbl.push_back(mk(50, 0, 0, 4'b0000, 0, 1, 0, 0, 0, 16'd3));
        // STOP mid-WARMUP (indices 19..22).
        tbl.push_back(mk( 0, 1, 0, 4'b0001, 1, 1, 0, 0, 1, 16'd0));
        tbl.push_back(mk(12, 0, 0, 4'b0001, 0, 0, 1, 0, 1, 16'd0));
        tbl.push_back(mk(13, 0, 1, 4'b0000, 0, 1, 0, 0, 0, 16'd0));
        tbl.push_back(mk(40, 0, 0, 4'b0000, 0, 1, 0, 0, 0, 16'd0));
        // START ignored while busy, START held across STOP (indices 23..28).
        tbl.push_back(mk( 0, 1, 0, 4'b0001, 1, 1, 0, 0, 1, 16'd0));
        tbl.push_back(mk( 1, 1, 0, 4'b0010, 0, 1, 0, 0, 1, 16'd0));
        tbl.push_back(mk( 2, 1, 0, 4'b0100, 0, 1, 0, 0, 1, 16'd0));
        tbl.push_back(mk( 3, 1, 1, 4'b0000, 0, 1, 0, 0, 0, 16'd0));
        tbl.push_back(mk( 4, 1, 0, 4'b0001, 1, 1, 0, 0, 1, 16'd0));
        tbl.push_back(mk( 5, 0, 1, 4'b0000, 0, 1, 0, 0, 0, 16'd0));

        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        #12;
        check("reset", 0, dut_pack(), RST_PACK);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
        check("reset_hold", 6, dut_pack(), RST_PACK);

        run_table(0, 18);
        run_table(19, 22);
        run_table(23, 28);

        // Counter wrap on the CNT_W=2 instance across five valid outputs.
        n_seen = 0;
        step(1'b1, 1'b0);
        for (int c = 0; c < 200 && n_seen < 5; c++) begin
            step(1'b0, 1'b0);
            if (valid) begin
                wrap_seen[n_seen] = cnt_w;
                n_seen++;
            end
        end
        if (n_seen < 5) begin
            n_vec++;
            n_err++;
            $display("FAIL wrap_timeout: got %0d valid pulses expected 5", n_seen);
        end else begin
            for (int k = 0; k < 5; k++)
                check("wrap_seq", k, 25'(wrap_seen[k]), 25'(wrap_exp[k]));
        end

        // Asynchronous reset between edges while in RUN.
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst", 0, dut_pack(), RST_PACK);
        check("async_rst_w", 0, 25'(cnt_w), 25'd0);
        m_active = 1'b0;
        m_t      = 0;
        m_cnt    = 0;
        @(posedge clk);
        #1;
        check("rst_held", 1, dut_pack(), RST_PACK);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

        // Randomized START/STOP traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 149) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
